// File: rtl/xosera_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xv : shared Xosera definitions used by the bus arbiter slice.
//   arb_state_t  - arbiter sequencing states (IDLE, SETUP, STROBE, HOLD)
//   ARB_NUM_REQ  - number of host bridges sharing the register bus
//   cs_ENABLED / cs_DISABLED - active-low chip-select levels
//   RnW_READ     - bus_rd_nwr level that selects a read
// ---------------------------------------------------------------------------
package xv;

  localparam int   ARB_NUM_REQ = 2;

  localparam logic cs_ENABLED  = 1'b0;
  localparam logic cs_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/xosera_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// xosera_bus_arbiter_if : requester-side handshake plus Xosera register bus.
//   Requester side : req_i, wr_i, bytesel_i, reg_num_i, wdata_i (in)
//                    ack_o, rdata_o, grant_o, busy_o            (out)
//   Xosera side    : bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
//                    bus_reg_num_o, bus_data_o (out), bus_data_i (in)
//   slave  modport : the arbiter
//   master modport : bridges plus the Xosera core (or a bench model)
// ---------------------------------------------------------------------------
interface xosera_bus_arbiter_if;
  import xv::*;

  logic [ARB_NUM_REQ-1:0]   req_i;
  logic [ARB_NUM_REQ-1:0]   wr_i;
  logic [ARB_NUM_REQ-1:0]   bytesel_i;
  logic [4*ARB_NUM_REQ-1:0] reg_num_i;
  logic [8*ARB_NUM_REQ-1:0] wdata_i;
  logic [ARB_NUM_REQ-1:0]   ack_o;
  logic [7:0]               rdata_o;
  logic                     grant_o;
  logic                     busy_o;
  logic                     bus_cs_n_o;
  logic                     bus_rd_nwr_o;
  logic                     bus_bytesel_o;
  logic [3:0]               bus_reg_num_o;
  logic [7:0]               bus_data_o;
  logic [7:0]               bus_data_i;

  modport slave (
    input  req_i, wr_i, bytesel_i, reg_num_i, wdata_i, bus_data_i,
    output ack_o, rdata_o, grant_o, busy_o,
    output bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o, bus_data_o
  );

  modport master (
    output req_i, wr_i, bytesel_i, reg_num_i, wdata_i, bus_data_i,
    input  ack_o, rdata_o, grant_o, busy_o,
    input  bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o, bus_data_o
  );

endinterface

// File: rtl/xosera_bus_arbiter.sv
// ---------------------------------------------------------------------------
// xosera_bus_arbiter : shares the Xosera 8-bit register bus between the SPI
// bridge (requester 0) and the UART bridge (requester 1). Each grant becomes
// one bus cycle: SETUP (CS high, fields stable), STROBE (CS low for
// STROBE_CYCLES cycles), HOLD (CS high, one-cycle ack to the winner).
//
// Parameters : STROBE_CYCLES (1..15, default 2) - CS-low width per access
// Ports      : clk     - pixel clock, sole clock
//              reset_i - synchronous active-high reset
//              bus_if  - xosera_bus_arbiter_if.slave (handshake + Xosera bus)
// Build option: XOSERA_ARB_ROUND_ROBIN_EN - when defined, ties go to the
//              requester not granted last; otherwise requester 0 always wins.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module xosera_bus_arbiter
  import xv::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_i,
  xosera_bus_arbiter_if.slave   bus_if
);

  // The strobe counter is 4 bits wide.
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("xosera_bus_arbiter: STROBE_CYCLES must be in 1..15");
  end

  arb_state_t             r_state;
  logic [3:0]             r_cnt;
  logic                   r_grant;
  logic [ARB_NUM_REQ-1:0] r_ack;
  logic [7:0]             r_rdata;
  logic                   r_busy;
  logic                   r_cs_n;
  logic                   r_rd_nwr;
  logic                   r_bytesel;
  logic [3:0]             r_reg_num;
  logic [7:0]             r_wdata;
  logic                   w_winner;

`ifdef XOSERA_ARB_ROUND_ROBIN_EN
  logic                   r_last_grant;

  // On a tie, hand the bus to whoever did not have it last.
  always_comb begin
    w_winner = 1'b0;
    if (bus_if.req_i[0] && bus_if.req_i[1]) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = ~bus_if.req_i[0];
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    w_winner = 1'b0;
    w_winner = ~bus_if.req_i[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_grant      <= 1'b0;
      r_ack        <= '0;
      r_rdata      <= 8'h00;
      r_busy       <= 1'b0;
      r_cs_n       <= cs_DISABLED;
      r_rd_nwr     <= RnW_READ;
      r_bytesel    <= 1'b0;
      r_reg_num    <= 4'h0;
      r_wdata      <= 8'h00;
`ifdef XOSERA_ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus_if.req_i) begin
            // Latch everything once; requester inputs are ignored until IDLE.
            r_grant   <= w_winner;
            r_rd_nwr  <= ~bus_if.wr_i[w_winner];
            r_bytesel <= bus_if.bytesel_i[w_winner];
            r_reg_num <= bus_if.reg_num_i[{w_winner, 2'b00} +: 4];
            r_wdata   <= bus_if.wdata_i[{w_winner, 3'b000} +: 8];
            r_busy    <= 1'b1;
            r_state   <= SETUP;
`ifdef XOSERA_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_winner;
`endif
          end
        end
        SETUP: begin
          r_cnt   <= 4'(STROBE_CYCLES - 1);
          r_cs_n  <= cs_ENABLED;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            // Sample read data at the end of the last strobe cycle.
            if (r_rd_nwr == RnW_READ) begin
              r_rdata <= bus_if.bus_data_i;
            end
            r_cs_n         <= cs_DISABLED;
            r_ack[r_grant] <= 1'b1;
            r_state        <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_if.ack_o         = r_ack;
  assign bus_if.rdata_o       = r_rdata;
  assign bus_if.grant_o       = r_grant;
  assign bus_if.busy_o        = r_busy;
  assign bus_if.bus_cs_n_o    = r_cs_n;
  assign bus_if.bus_rd_nwr_o  = r_rd_nwr;
  assign bus_if.bus_bytesel_o = r_bytesel;
  assign bus_if.bus_reg_num_o = r_reg_num;
  assign bus_if.bus_data_o    = r_wdata;

endmodule

// File: tb/tb_xosera_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xosera_bus_arbiter : directed bench for xosera_bus_arbiter.
// Instance 0 uses the default STROBE_CYCLES (2); instances 1 and 2 use
// STROBE_CYCLES 1 and 15. Requester fields and the Xosera read-data model
// are shared; each instance has its own req vector.
// ---------------------------------------------------------------------------
module tb_xosera_bus_arbiter;
  import xv::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [1:0]  req_a [3];
  logic [1:0]  wr;
  logic [1:0]  bytesel;
  logic [7:0]  reg_num;
  logic [15:0] wdata;
  logic [7:0]  bus_rdata;

  xosera_bus_arbiter_if if0 ();
  xosera_bus_arbiter_if if1 ();
  xosera_bus_arbiter_if if15 ();

  xosera_bus_arbiter #(.STROBE_CYCLES(2))  u_dut   (.clk(clk), .reset_i(reset_i), .bus_if(if0));
  xosera_bus_arbiter #(.STROBE_CYCLES(1))  u_dut1  (.clk(clk), .reset_i(reset_i), .bus_if(if1));
  xosera_bus_arbiter #(.STROBE_CYCLES(15)) u_dut15 (.clk(clk), .reset_i(reset_i), .bus_if(if15));

  assign if0.req_i  = req_a[0]; assign if1.req_i  = req_a[1]; assign if15.req_i  = req_a[2];
  assign if0.wr_i   = wr;       assign if1.wr_i   = wr;       assign if15.wr_i   = wr;
  assign if0.bytesel_i = bytesel; assign if1.bytesel_i = bytesel; assign if15.bytesel_i = bytesel;
  assign if0.reg_num_i = reg_num; assign if1.reg_num_i = reg_num; assign if15.reg_num_i = reg_num;
  assign if0.wdata_i   = wdata;   assign if1.wdata_i   = wdata;   assign if15.wdata_i   = wdata;
  assign if0.bus_data_i = bus_rdata; assign if1.bus_data_i = bus_rdata; assign if15.bus_data_i = bus_rdata;

  logic       cs_n_a [3];
  logic [1:0] ack_a  [3];
  logic       busy_a [3];
  logic [7:0] rdata_a[3];
  logic       grant_a[3];
  logic       rnw_a  [3];
  logic       bs_a   [3];
  logic [3:0] rn_a   [3];
  logic [7:0] do_a   [3];

  assign cs_n_a[0] = if0.bus_cs_n_o;    assign cs_n_a[1] = if1.bus_cs_n_o;    assign cs_n_a[2] = if15.bus_cs_n_o;
  assign ack_a[0]  = if0.ack_o;         assign ack_a[1]  = if1.ack_o;         assign ack_a[2]  = if15.ack_o;
  assign busy_a[0] = if0.busy_o;        assign busy_a[1] = if1.busy_o;        assign busy_a[2] = if15.busy_o;
  assign rdata_a[0] = if0.rdata_o;      assign rdata_a[1] = if1.rdata_o;      assign rdata_a[2] = if15.rdata_o;
  assign grant_a[0] = if0.grant_o;      assign grant_a[1] = if1.grant_o;      assign grant_a[2] = if15.grant_o;
  assign rnw_a[0]  = if0.bus_rd_nwr_o;  assign rnw_a[1]  = if1.bus_rd_nwr_o;  assign rnw_a[2]  = if15.bus_rd_nwr_o;
  assign bs_a[0]   = if0.bus_bytesel_o; assign bs_a[1]   = if1.bus_bytesel_o; assign bs_a[2]   = if15.bus_bytesel_o;
  assign rn_a[0]   = if0.bus_reg_num_o; assign rn_a[1]   = if1.bus_reg_num_o; assign rn_a[2]   = if15.bus_reg_num_o;
  assign do_a[0]   = if0.bus_data_o;    assign do_a[1]   = if1.bus_data_o;    assign do_a[2]   = if15.bus_data_o;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on instance inst by requester id; returns what was observed.
  // Cycle n counts clock edges after the request was raised.
  task automatic run_access(input int inst, input logic id, input logic w, input logic bs,
                            input logic [3:0] rn, input logic [7:0] wd, input logic [7:0] rdv,
                            output int ack_cyc, output int cs_low, output int busy_cyc,
                            output logic [1:0] ack_val, output logic [7:0] rd_val,
                            output logic grant_val, output int fld_bad);
    wr[id]                = w;
    bytesel[id]           = bs;
    reg_num[id*4 +: 4]    = rn;
    wdata[id*8 +: 8]      = wd;
    bus_rdata             = rdv;
    ack_cyc = -1; cs_low = 0; busy_cyc = 0; fld_bad = 0;
    ack_val = 2'b00; rd_val = 8'h00; grant_val = 1'b0;
    req_a[inst][id] = 1'b1;
    for (int n = 1; n <= 40 && ack_cyc < 0; n++) begin
      tick();
      if (cs_n_a[inst] == 1'b0) begin
        cs_low++;
        if (rnw_a[inst] !== ~w || bs_a[inst] !== bs || rn_a[inst] !== rn || do_a[inst] !== wd)
          fld_bad++;
      end
      if (busy_a[inst]) busy_cyc++;
      if (ack_a[inst] != 2'b00) begin
        ack_cyc   = n;
        ack_val   = ack_a[inst];
        rd_val    = rdata_a[inst];
        grant_val = grant_a[inst];
      end
    end
    req_a[inst][id] = 1'b0;
    tick();
    $display("xact inst=%0d req=%0d wr=%0d reg=%0h ack=%b rdata=%02h ack_cycle=%0d cs_low=%0d",
             inst, id, w, rn, ack_val, rd_val, ack_cyc, cs_low);
  endtask

  typedef struct {
    logic       id;
    logic       w;
    logic       bs;
    logic [3:0] rn;
    logic [7:0] wd;
    logic [7:0] rdv;
    logic [1:0] exp_ack;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  int         ack_cyc, cs_low, busy_cyc, fld_bad;
  logic [1:0] ack_val;
  logic [7:0] rd_val;
  logic       grant_val;
  int         ack_times [4];
  logic       ack_grants[4];
  logic [1:0] ack_vals  [4];
  int         nacks;
  int         stray_acks;
  logic       exp_g;

  initial begin
    // Writes leave rdata unchanged, so exp_rdata carries the previous read forward.
    vecs[0] = '{id:1'b0, w:1'b1, bs:1'b1, rn:4'h3, wd:8'hA5, rdv:8'h00, exp_ack:2'b01, exp_rdata:8'h00};
    vecs[1] = '{id:1'b1, w:1'b0, bs:1'b0, rn:4'hC, wd:8'h00, rdv:8'h5A, exp_ack:2'b10, exp_rdata:8'h5A};
    vecs[2] = '{id:1'b0, w:1'b0, bs:1'b0, rn:4'h7, wd:8'h12, rdv:8'h3C, exp_ack:2'b01, exp_rdata:8'h3C};
    vecs[3] = '{id:1'b1, w:1'b1, bs:1'b1, rn:4'hF, wd:8'h81, rdv:8'hFF, exp_ack:2'b10, exp_rdata:8'h3C};
    vecs[4] = '{id:1'b0, w:1'b0, bs:1'b1, rn:4'h0, wd:8'h44, rdv:8'hC3, exp_ack:2'b01, exp_rdata:8'hC3};
    vecs[5] = '{id:1'b1, w:1'b1, bs:1'b0, rn:4'h9, wd:8'h00, rdv:8'h11, exp_ack:2'b10, exp_rdata:8'hC3};

    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) req_a[i] = 2'b00;
    wr = 2'b00; bytesel = 2'b00; reg_num = 8'h00; wdata = 16'h0000; bus_rdata = 8'h00;
    tick(); tick();

    // Reset state
    check("rst_cs_n",    32'(cs_n_a[0]),  32'h1);
    check("rst_rd_nwr",  32'(rnw_a[0]),   32'h1);
    check("rst_bytesel", 32'(bs_a[0]),    32'h0);
    check("rst_reg_num", 32'(rn_a[0]),    32'h0);
    check("rst_data",    32'(do_a[0]),    32'h0);
    check("rst_rdata",   32'(rdata_a[0]), 32'h0);
    check("rst_ack",     32'(ack_a[0]),   32'h0);
    check("rst_grant",   32'(grant_a[0]), 32'h0);
    check("rst_busy",    32'(busy_a[0]),  32'h0);
    reset_i = 1'b0;
    tick();

    // Table of single accesses on the default instance
    for (int v = 0; v < 6; v++) begin
      run_access(0, vecs[v].id, vecs[v].w, vecs[v].bs, vecs[v].rn, vecs[v].wd, vecs[v].rdv,
                 ack_cyc, cs_low, busy_cyc, ack_val, rd_val, grant_val, fld_bad);
      check($sformatf("v%0d_ack", v),       32'(ack_val),   32'(vecs[v].exp_ack));
      check($sformatf("v%0d_rdata", v),     32'(rd_val),    32'(vecs[v].exp_rdata));
      check($sformatf("v%0d_grant", v),     32'(grant_val), 32'(vecs[v].id));
      check($sformatf("v%0d_ack_cycle", v), 32'(ack_cyc),   32'd4);
      check($sformatf("v%0d_cs_low", v),    32'(cs_low),    32'd2);
      check($sformatf("v%0d_fields", v),    32'(fld_bad),   32'd0);
      check($sformatf("v%0d_busy_idle", v), 32'(busy_a[0]), 32'd0);
    end

    // Both requesters held continuously
    wr = 2'b00; reg_num = 8'h21; bus_rdata = 8'h77;
    req_a[0] = 2'b11;
    nacks = 0;
    for (int n = 1; n <= 60 && nacks < 4; n++) begin
      tick();
      if (ack_a[0] != 2'b00) begin
        ack_times[nacks]  = n;
        ack_grants[nacks] = grant_a[0];
        ack_vals[nacks]   = ack_a[0];
        $display("xact contended ack#%0d cycle=%0d grant=%0d ack=%b", nacks, n, grant_a[0], ack_a[0]);
        nacks++;
      end
    end
    req_a[0] = 2'b00;
    check("rr_num_acks", 32'(nacks), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef XOSERA_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      check($sformatf("rr_grant%0d", i), 32'(ack_grants[i]), 32'(exp_g));
      check($sformatf("rr_ackval%0d", i), 32'(ack_vals[i]), exp_g ? 32'h2 : 32'h1);
      if (i > 0) check($sformatf("rr_spacing%0d", i), 32'(ack_times[i] - ack_times[i-1]), 32'd5);
    end
    tick(); tick();

    // STROBE_CYCLES = 1 and 15
    run_access(1, 1'b0, 1'b1, 1'b0, 4'h5, 8'h3E, 8'h00, ack_cyc, cs_low, busy_cyc, ack_val, rd_val, grant_val, fld_bad);
    check("s1_cs_low",    32'(cs_low),   32'd1);
    check("s1_ack_cycle", 32'(ack_cyc),  32'd3);
    check("s1_busy",      32'(busy_cyc), 32'd3);
    check("s1_ack",       32'(ack_val),  32'h1);
    run_access(2, 1'b1, 1'b0, 1'b1, 4'hA, 8'h00, 8'h96, ack_cyc, cs_low, busy_cyc, ack_val, rd_val, grant_val, fld_bad);
    check("s15_cs_low",    32'(cs_low),   32'd15);
    check("s15_ack_cycle", 32'(ack_cyc),  32'd17);
    check("s15_busy",      32'(busy_cyc), 32'd17);
    check("s15_ack",       32'(ack_val),  32'h2);
    check("s15_rdata",     32'(rd_val),   32'h96);
    check("s15_fields",    32'(fld_bad),  32'd0);

    // Reset during the first STROBE cycle
    wr = 2'b01; bytesel = 2'b00; reg_num = 8'h04; wdata = 16'h0066;
    req_a[0] = 2'b01;
    tick();
    tick();
    check("mid_strobe_cs_low", 32'(cs_n_a[0]), 32'h0);
    reset_i  = 1'b1;
    req_a[0] = 2'b00;
    tick();
    check("mid_rst_cs_n", 32'(cs_n_a[0]), 32'h1);
    check("mid_rst_ack",  32'(ack_a[0]),  32'h0);
    check("mid_rst_busy", 32'(busy_a[0]), 32'h0);
    reset_i = 1'b0;
    stray_acks = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (ack_a[0] != 2'b00 || cs_n_a[0] != 1'b1) stray_acks++;
    end
    check("mid_rst_quiet", 32'(stray_acks), 32'd0);
    run_access(0, 1'b0, 1'b0, 1'b1, 4'h2, 8'h00, 8'hE7, ack_cyc, cs_low, busy_cyc, ack_val, rd_val, grant_val, fld_bad);
    check("post_rst_ack",   32'(ack_val), 32'h1);
    check("post_rst_cycle", 32'(ack_cyc), 32'd4);
    check("post_rst_rdata", 32'(rd_val),  32'hE7);

    // Requester 0 drops req in SETUP
    wr = 2'b01; bytesel = 2'b01; reg_num = 8'h0B; wdata = 16'h00C9;
    req_a[0] = 2'b01;
    tick();
    req_a[0] = 2'b00;
    ack_cyc = -1; ack_val = 2'b00;
    for (int n = 2; n <= 12 && ack_cyc < 0; n++) begin
      tick();
      if (ack_a[0] != 2'b00) begin
        ack_cyc = n;
        ack_val = ack_a[0];
      end
    end
    $display("xact early-drop ack=%b ack_cycle=%0d", ack_val, ack_cyc);
    check("drop_ack",   32'(ack_val), 32'h1);
    check("drop_cycle", 32'(ack_cyc), 32'd4);
    tick();
    check("drop_idle_busy", 32'(busy_a[0]), 32'h0);
    check("drop_idle_cs",   32'(cs_n_a[0]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
